// File: rtl/fsum_pack_if.sv
// Handshake and FIFO-write bundle between the full-sum stage, fsum_pack and the output FIFO.
// LANES must match the packer instance it is bound to.
interface fsum_pack_if #(
  parameter int LANES = 8
);
  logic [15:0]          result;
  logic                 result_valid;
  logic                 result_last;
  logic                 in_ready;
  logic                 o_fifo_full;
  logic                 o_fifo_wr_en;
  logic [16*LANES-1:0]  o_fifo_din;
  logic [15:0]          word_count;
  logic                 done;

  modport master (
    input  result, result_valid, result_last, o_fifo_full,
    output in_ready, o_fifo_wr_en, o_fifo_din, word_count, done
  );

  modport slave (
    output result, result_valid, result_last, o_fifo_full,
    input  in_ready, o_fifo_wr_en, o_fifo_din, word_count, done
  );
endinterface

// File: rtl/fsum_pack.sv
// Packs LANES fp16 full-sum results (lane 0 in the low bits) into one output-FIFO word.
// Optional ReLU at acceptance when FSUM_PACK_RELU_EN is defined.
module fsum_pack #(
  parameter int          LANES     = 8,
  parameter logic [15:0] PAD_VALUE = 16'h0000
) (
  input  logic          clk,
  input  logic          rst,
  fsum_pack_if.master   bus
);
  localparam int IDXW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic {FILL, WRITE} state_t;

  state_t                 r_state, w_state_nxt;
  logic [LANES-1:0][15:0] r_lanes, w_lanes_nxt;
  logic [LANES-1:0][15:0] r_din, w_din_nxt;
  logic [IDXW-1:0]        r_lane_idx, w_lane_idx_nxt;
  logic                   r_last, w_last_nxt;
  logic [15:0]            r_word_count;
  logic                   w_accept;
  logic                   w_wr_en;
  logic [15:0]            w_res;

`ifdef FSUM_PACK_RELU_EN
  assign w_res = bus.result[15] ? 16'h0000 : bus.result;
`else
  assign w_res = bus.result;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= FILL;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_lanes_nxt    = r_lanes;
    w_din_nxt      = r_din;
    w_lane_idx_nxt = r_lane_idx;
    w_last_nxt     = r_last;
    w_accept       = 1'b0;
    w_wr_en        = 1'b0;
    case (r_state)
      FILL: begin
        w_accept = bus.result_valid && !rst;
        if (w_accept) begin
          w_lanes_nxt[r_lane_idx] = w_res;
          w_lane_idx_nxt          = r_lane_idx + IDXW'(1);
          // The output word is captured here so it is registered for the whole WRITE stall.
          if (bus.result_last || (r_lane_idx == IDXW'(LANES - 1))) begin
            w_state_nxt = WRITE;
            w_last_nxt  = bus.result_last;
            w_din_nxt   = w_lanes_nxt;
          end
        end
      end
      WRITE: begin
        if (!bus.o_fifo_full && !rst) begin
          w_wr_en        = 1'b1;
          w_state_nxt    = FILL;
          w_lanes_nxt    = {LANES{PAD_VALUE}};
          w_lane_idx_nxt = '0;
          w_last_nxt     = 1'b0;
        end
      end
      default: w_state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lanes      <= {LANES{PAD_VALUE}};
      r_din        <= '0;
      r_lane_idx   <= '0;
      r_last       <= 1'b0;
      r_word_count <= '0;
    end else begin
      r_lanes    <= w_lanes_nxt;
      r_din      <= w_din_nxt;
      r_lane_idx <= w_lane_idx_nxt;
      r_last     <= w_last_nxt;
      if (w_wr_en) r_word_count <= r_word_count + 16'd1;
    end
  end

  assign bus.in_ready     = (r_state == FILL) && !rst;
  assign bus.o_fifo_wr_en = w_wr_en;
  assign bus.o_fifo_din   = r_din;
  assign bus.word_count   = r_word_count;
  assign bus.done         = w_wr_en && r_last;
endmodule

// File: tb/tb_fsum_pack.sv
// Directed bench for fsum_pack: reset, full/partial words, back-pressure, ReLU, mid-fill reset, multiple-of-8 last.
module tb_fsum_pack;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   full_viol = 0;
  logic [127:0] wr_q[$];
  logic         done_q[$];

  always #5 clk = ~clk;

  fsum_pack_if #(.LANES(8)) bus();

  fsum_pack #(.LANES(8), .PAD_VALUE(16'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always @(negedge clk) begin
    if (bus.o_fifo_wr_en) begin
      wr_q.push_back(bus.o_fifo_din);
      done_q.push_back(bus.done);
      if (bus.o_fifo_full) full_viol++;
    end
  end

  // Presents one result from posedge+1 and returns #1 after the accepting edge.
  task automatic send(input logic [15:0] v, input logic last);
    bit ok;
    ok = 1'b0;
    bus.result = v;
    bus.result_valid = 1'b1;
    bus.result_last = last;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
    end
    bus.result_valid = 1'b0;
    bus.result_last = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL send_timeout: result %h not accepted within 50 cycles", v);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.result = '0; bus.result_valid = 1'b0; bus.result_last = 1'b0; bus.o_fifo_full = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
    total++; if (bus.o_fifo_wr_en !== 1'b0) begin bad++; $display("FAIL rst_wr_en: got %b want 0", bus.o_fifo_wr_en); end
    total++; if (bus.o_fifo_din !== 128'h0) begin bad++; $display("FAIL rst_din: got %h want 0", bus.o_fifo_din); end
    total++; if (bus.word_count !== 16'h0) begin bad++; $display("FAIL rst_word_count: got %h want 0", bus.word_count); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", bus.done); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready: got %b want 1", bus.in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_full_word;
    wr_q.delete(); done_q.delete();
    for (int i = 0; i < 8; i++) send(16'h3C00 + 16'(i), 1'b0);
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL full_ready_low: got %b want 0", bus.in_ready); end
    total++; if (bus.o_fifo_wr_en !== 1'b1) begin bad++; $display("FAIL full_wr_en: got %b want 1", bus.o_fifo_wr_en); end
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL full_ready_back: got %b want 1", bus.in_ready); end
    total++; if (bus.o_fifo_wr_en !== 1'b0) begin bad++; $display("FAIL full_wr_en_once: got %b want 0", bus.o_fifo_wr_en); end
    total++; if (wr_q.size() !== 1) begin bad++; $display("FAIL full_writes: got %0d want 1", wr_q.size()); end
    else begin
      total++;
      if (wr_q[0] !== 128'h3C07_3C06_3C05_3C04_3C03_3C02_3C01_3C00) begin
        bad++; $display("FAIL full_din: got %h want 3c073c063c053c043c033c023c013c00", wr_q[0]);
      end
      total++; if (done_q[0] !== 1'b0) begin bad++; $display("FAIL full_done: got %b want 0", done_q[0]); end
    end
    total++; if (bus.word_count !== 16'd1) begin bad++; $display("FAIL full_word_count: got %0d want 1", bus.word_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_partial;
    wr_q.delete(); done_q.delete();
    send(16'h4000, 1'b0);
    send(16'h4200, 1'b0);
    send(16'h4400, 1'b1);
    @(negedge clk);
    total++; if (bus.o_fifo_wr_en !== 1'b1) begin bad++; $display("FAIL part_wr_en: got %b want 1", bus.o_fifo_wr_en); end
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL part_done: got %b want 1", bus.done); end
    repeat (2) @(negedge clk);
    total++; if (wr_q.size() !== 1) begin bad++; $display("FAIL part_writes: got %0d want 1", wr_q.size()); end
    else begin
      total++;
      if (wr_q[0] !== {80'h0, 48'h4400_4200_4000}) begin
        bad++; $display("FAIL part_din: got %h want %h", wr_q[0], {80'h0, 48'h4400_4200_4000});
      end
    end
    total++; if (bus.word_count !== 16'd2) begin bad++; $display("FAIL part_word_count: got %0d want 2", bus.word_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    logic [127:0] exp;
    exp = 128'h1007_1006_1005_1004_1003_1002_1001_1000;
    wr_q.delete(); done_q.delete();
    bus.o_fifo_full = 1'b1;
    for (int i = 0; i < 8; i++) send(16'h1000 + 16'(i), 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++; if (bus.o_fifo_wr_en !== 1'b0) begin bad++; $display("FAIL bp_wr_en_c%0d: got %b want 0", c, bus.o_fifo_wr_en); end
      total++; if (bus.o_fifo_din !== exp) begin bad++; $display("FAIL bp_din_c%0d: got %h want %h", c, bus.o_fifo_din, exp); end
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_c%0d: got %b want 0", c, bus.in_ready); end
    end
    @(posedge clk); #1;
    bus.o_fifo_full = 1'b0;
    @(negedge clk);
    total++; if (bus.o_fifo_wr_en !== 1'b1) begin bad++; $display("FAIL bp_release_wr_en: got %b want 1", bus.o_fifo_wr_en); end
    repeat (2) @(negedge clk);
    total++; if (wr_q.size() !== 1) begin bad++; $display("FAIL bp_writes: got %0d want 1", wr_q.size()); end
    else begin
      total++; if (wr_q[0] !== exp) begin bad++; $display("FAIL bp_word: got %h want %h", wr_q[0], exp); end
    end
    total++; if (bus.word_count !== 16'd3) begin bad++; $display("FAIL bp_word_count: got %0d want 3", bus.word_count); end
    total++; if (full_viol !== 0) begin bad++; $display("FAIL bp_wr_while_full: got %0d want 0", full_viol); end
    @(posedge clk); #1;
  endtask

  task automatic test_relu;
    logic [127:0] exp;
`ifdef FSUM_PACK_RELU_EN
    exp = {64'h0, 16'h3C00, 16'h0000, 16'h0000, 16'h0000};
`else
    exp = {64'h0, 16'h3C00, 16'hFE00, 16'h8000, 16'hBC00};
`endif
    wr_q.delete(); done_q.delete();
    send(16'hBC00, 1'b0);
    send(16'h8000, 1'b0);
    send(16'hFE00, 1'b0);
    send(16'h3C00, 1'b1);
    repeat (3) @(negedge clk);
    total++; if (wr_q.size() !== 1) begin bad++; $display("FAIL relu_writes: got %0d want 1", wr_q.size()); end
    else begin
      total++; if (wr_q[0] !== exp) begin bad++; $display("FAIL relu_din: got %h want %h", wr_q[0], exp); end
      total++; if (done_q[0] !== 1'b1) begin bad++; $display("FAIL relu_done: got %b want 1", done_q[0]); end
    end
    total++; if (bus.word_count !== 16'd4) begin bad++; $display("FAIL relu_word_count: got %0d want 4", bus.word_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midfill;
    wr_q.delete(); done_q.delete();
    for (int i = 0; i < 5; i++) send(16'h7000 + 16'(i), 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (wr_q.size() !== 0) begin bad++; $display("FAIL mid_rst_writes: got %0d want 0", wr_q.size()); end
    total++; if (bus.word_count !== 16'd0) begin bad++; $display("FAIL mid_rst_word_count: got %0d want 0", bus.word_count); end
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) send(16'h2000 + 16'(i), 1'b0);
    repeat (2) @(negedge clk);
    total++; if (wr_q.size() !== 1) begin bad++; $display("FAIL mid_post_writes: got %0d want 1", wr_q.size()); end
    else begin
      total++;
      if (wr_q[0] !== 128'h2007_2006_2005_2004_2003_2002_2001_2000) begin
        bad++; $display("FAIL mid_post_din: got %h want 20072006200520042003200220012000", wr_q[0]);
      end
    end
    total++; if (bus.word_count !== 16'd1) begin bad++; $display("FAIL mid_post_word_count: got %0d want 1", bus.word_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    wr_q.delete(); done_q.delete();
    for (int i = 0; i < 16; i++) send(16'h5000 + 16'(i), (i == 15) ? 1'b1 : 1'b0);
    repeat (6) @(negedge clk);
    total++; if (wr_q.size() !== 2) begin bad++; $display("FAIL m8_writes: got %0d want 2", wr_q.size()); end
    else begin
      total++;
      if (wr_q[0] !== 128'h5007_5006_5005_5004_5003_5002_5001_5000) begin
        bad++; $display("FAIL m8_word0: got %h want 50075006500550045003500250015000", wr_q[0]);
      end
      total++;
      if (wr_q[1] !== 128'h500F_500E_500D_500C_500B_500A_5009_5008) begin
        bad++; $display("FAIL m8_word1: got %h want 500f500e500d500c500b500a50095008", wr_q[1]);
      end
      total++; if (done_q[0] !== 1'b0) begin bad++; $display("FAIL m8_done0: got %b want 0", done_q[0]); end
      total++; if (done_q[1] !== 1'b1) begin bad++; $display("FAIL m8_done1: got %b want 1", done_q[1]); end
    end
    total++; if (bus.word_count !== 16'd3) begin bad++; $display("FAIL m8_word_count: got %0d want 3", bus.word_count); end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_partial();
    test_backpressure();
    test_relu();
    test_reset_midfill();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
